// File: rtl/freq_est_sequencer_pkg.sv
// Shared types and constants for the freq_est measurement sequencer.
`timescale 1ns/1ps
package freq_est_sequencer_pkg;

    // Default counter width of the freq_est result bus
    localparam int CNT_W_DEF = 10;

    // System clock rate the window lengths are expressed against
    localparam int CLK_HZ = 16_000_000;

    // Sequencer states
    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_RUN        = 3'd1,
        S_STOP       = 3'd2,
        S_WAIT_VALID = 3'd3,
        S_ACCUM      = 3'd4,
        S_DONE       = 3'd5
    } state_t;

    // Largest of three phase lengths; sizes the shared phase timer
    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/freq_est_sequencer_if.sv
// Control, freq_est and result-consumer signals of the sequencer.
`timescale 1ns/1ps
interface freq_est_sequencer_if
    import freq_est_sequencer_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
);
    logic             start;
    logic             abort;
    logic             busy;
    logic             est_stop;
    logic             est_valid;
    logic [CNT_W-1:0] est_result;
    logic [CNT_W-1:0] avg_result;
    logic             avg_valid;
    logic             avg_ready;
    logic             timeout_err;

    // Sequencer side
    modport slave (
        input  start, abort, est_valid, est_result, avg_ready,
        output busy, est_stop, avg_result, avg_valid, timeout_err
    );

    // System control / freq_est / consumer side
    modport master (
        output start, abort, est_valid, est_result, avg_ready,
        input  busy, est_stop, avg_result, avg_valid, timeout_err
    );
endinterface

// File: rtl/freq_est_phase_timer.sv
// Loadable down-counter with zero flag, reused by every timed phase.
`timescale 1ns/1ps
module freq_est_phase_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         zero
);
    logic [W-1:0] cnt;

    // Load on phase entry, otherwise count down and park at zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);
endmodule

// File: rtl/freq_est_sequencer.sv
// Sequences freq_est windows, averages 2**LOG2_AVG results and hands the
// mean to a consumer over valid/ready.
`timescale 1ns/1ps
module freq_est_sequencer
    import freq_est_sequencer_pkg::*;
#(
    parameter int CNT_W       = CNT_W_DEF,
    parameter int RUN_CYCLES  = 5000,
    parameter int STOP_CYCLES = 100,
    parameter int LOG2_AVG    = 2,
    parameter int TIMEOUT     = 255
) (
    input  logic                 clk,
    input  logic                 RESETn,
    freq_est_sequencer_if.slave  bus
);
    localparam int N_AVG = 1 << LOG2_AVG;
    localparam int ACC_W = CNT_W + LOG2_AVG;
    localparam int MC_W  = LOG2_AVG + 1;
    localparam int T_MAX = max3(RUN_CYCLES, STOP_CYCLES, TIMEOUT);
    localparam int TMR_W = $clog2(T_MAX + 1);

    // Timer reload values: a phase of L clocks counts L-1 down to 0
    localparam logic [TMR_W-1:0] RUN_LD  = TMR_W'(RUN_CYCLES - 1);
    localparam logic [TMR_W-1:0] STOP_LD = TMR_W'(STOP_CYCLES - 1);
    localparam logic [TMR_W-1:0] TO_LD   = TMR_W'(TIMEOUT - 1);

    state_t             state, state_nx;
    logic               tmr_load;
    logic [TMR_W-1:0]   tmr_val;
    logic               tmr_zero;

    logic               got_valid;
    logic [CNT_W-1:0]   latched;
    logic [ACC_W-1:0]   acc, acc_new;
    logic [MC_W-1:0]    meas_cnt, meas_nx;
    logic [CNT_W-1:0]   avg_result;
    logic               avg_valid;
    logic               timeout_err;

    logic seq_start, seq_abort, cap_en, accum_en, done_en, timeout_en, release_en;

    // Truncating mean of the accumulated measurements
    function automatic logic [CNT_W-1:0] avg_of(input logic [ACC_W-1:0] a);
        return CNT_W'(a >> LOG2_AVG);
    endfunction

    assign acc_new = acc + ACC_W'(latched);
    assign meas_nx = meas_cnt + 1'b1;

    freq_est_phase_timer #(.W(TMR_W)) u_timer (
        .clk      (clk),
        .rst_n    (RESETn),
        .load     (tmr_load),
        .load_val (tmr_val),
        .zero     (tmr_zero)
    );

    // State register
    always_ff @(posedge clk or negedge RESETn) begin
        if (!RESETn) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Next-state decode and datapath strobes; abort overrides everything outside IDLE
    always_comb begin
        state_nx   = state;
        tmr_load   = 1'b0;
        tmr_val    = '0;
        seq_start  = 1'b0;
        seq_abort  = 1'b0;
        cap_en     = 1'b0;
        accum_en   = 1'b0;
        done_en    = 1'b0;
        timeout_en = 1'b0;
        release_en = 1'b0;
        if (state != S_IDLE && bus.abort) begin
            state_nx  = S_IDLE;
            seq_abort = 1'b1;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start && !bus.abort) begin
                        state_nx  = S_RUN;
                        seq_start = 1'b1;
                        tmr_load  = 1'b1;
                        tmr_val   = RUN_LD;
                    end
                end
                S_RUN: begin
                    if (tmr_zero) begin
                        state_nx = S_STOP;
                        tmr_load = 1'b1;
                        tmr_val  = STOP_LD;
                    end
                end
                S_STOP: begin
                    cap_en = bus.est_valid && !got_valid;
                    if (tmr_zero) begin
                        // A valid in the final STOP clock still counts as on time
                        if (got_valid || bus.est_valid) begin
                            state_nx = S_ACCUM;
                        end else begin
                            state_nx = S_WAIT_VALID;
                            tmr_load = 1'b1;
                            tmr_val  = TO_LD;
                        end
                    end
                end
                S_WAIT_VALID: begin
                    if (bus.est_valid) begin
                        cap_en   = 1'b1;
                        state_nx = S_ACCUM;
                    end else if (tmr_zero) begin
                        state_nx   = S_IDLE;
                        timeout_en = 1'b1;
                    end
                end
                S_ACCUM: begin
                    accum_en = 1'b1;
                    if (meas_nx == MC_W'(N_AVG)) begin
                        state_nx = S_DONE;
                        done_en  = 1'b1;
                    end else begin
                        state_nx = S_RUN;
                        tmr_load = 1'b1;
                        tmr_val  = RUN_LD;
                    end
                end
                S_DONE: begin
                    if (bus.avg_ready) begin
                        state_nx   = S_IDLE;
                        release_en = 1'b1;
                    end
                end
                default: state_nx = S_IDLE;
            endcase
        end
    end

    // Result latch, accumulator, measurement count and output registers
    always_ff @(posedge clk or negedge RESETn) begin
        if (!RESETn) begin
            got_valid   <= 1'b0;
            latched     <= '0;
            acc         <= '0;
            meas_cnt    <= '0;
            avg_result  <= '0;
            avg_valid   <= 1'b0;
            timeout_err <= 1'b0;
        end else begin
            if (seq_start) begin
                acc         <= '0;
                meas_cnt    <= '0;
                timeout_err <= 1'b0;
                got_valid   <= 1'b0;
            end
            if (cap_en) begin
                latched   <= bus.est_result;
                got_valid <= 1'b1;
            end
            if (accum_en) begin
                acc       <= acc_new;
                meas_cnt  <= meas_nx;
                got_valid <= 1'b0;
            end
            if (done_en) begin
                avg_result <= avg_of(acc_new);
                avg_valid  <= 1'b1;
            end
            if (release_en) begin
                avg_valid <= 1'b0;
            end
            if (timeout_en) begin
                timeout_err <= 1'b1;
                acc         <= '0;
            end
            if (seq_abort) begin
                acc       <= '0;
                avg_valid <= 1'b0;
            end
        end
    end

    assign bus.busy        = (state != S_IDLE);
    assign bus.est_stop    = (state != S_RUN);
    assign bus.avg_result  = avg_result;
    assign bus.avg_valid   = avg_valid;
    assign bus.timeout_err = timeout_err;
endmodule

// File: tb/tb_freq_est_sequencer.sv
// Randomized self-checking bench for freq_est_sequencer with a behavioural
// freq_est responder and a sequence-level reference model.
`timescale 1ns/1ps
module tb_freq_est_sequencer;
    import freq_est_sequencer_pkg::*;

    localparam int CNT_W = 10;
    localparam int R     = 20;
    localparam int S     = 4;
    localparam int T     = 8;
    localparam int L     = 2;
    localparam int N     = 1 << L;

    logic clk    = 1'b0;
    logic RESETn = 1'b0;

    freq_est_sequencer_if #(.CNT_W(CNT_W)) bus ();

    freq_est_sequencer #(
        .CNT_W       (CNT_W),
        .RUN_CYCLES  (R),
        .STOP_CYCLES (S),
        .LOG2_AVG    (L),
        .TIMEOUT     (T)
    ) dut (
        .clk    (clk),
        .RESETn (RESETn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Per-measurement responder behaviour: d_tab = STOP-relative clock of the
    // valid pulse (0 = never), v_tab = value returned
    int               d_tab [N];
    logic [CNT_W-1:0] v_tab [N];
    bit               run_noise   = 1'b0;
    bit               start_noise = 1'b0;
    int               meas_idx    = 0;
    int               stop_age    = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Behavioural freq_est: pulses valid on the configured STOP clock, then a
    // second bogus pulse that must be ignored; optional noise during RUN
    always @(negedge clk) begin
        bus.est_valid  = 1'b0;
        bus.est_result = CNT_W'($urandom);
        if (bus.busy && bus.est_stop) begin
            stop_age++;
            if (meas_idx < N && d_tab[meas_idx] != 0) begin
                if (stop_age == d_tab[meas_idx]) begin
                    bus.est_valid  = 1'b1;
                    bus.est_result = v_tab[meas_idx];
                end else if (stop_age == d_tab[meas_idx] + 1) begin
                    bus.est_valid  = 1'b1;
                    bus.est_result = ~v_tab[meas_idx];
                end
            end
        end else begin
            if (stop_age != 0) meas_idx++;
            stop_age = 0;
            if (!bus.busy) meas_idx = 0;
            else if (run_noise && $urandom_range(0, 7) == 0) bus.est_valid = 1'b1;
        end
    end

    // Sequence-level reference: cycles from start to outcome, outcome, mean,
    // and how many RUN windows are opened
    task automatic model_seq(output int cycles, output bit to, output int avg, output int wins);
        int sum;
        sum    = 0;
        cycles = 0;
        to     = 1'b0;
        wins   = 0;
        for (int k = 0; k < N; k++) begin
            wins++;
            if (d_tab[k] == 0 || d_tab[k] > S + T) begin
                cycles += R + S + T;
                to = 1'b1;
                break;
            end
            cycles += R + ((d_tab[k] > S) ? d_tab[k] : S) + 1;
            sum    += int'(v_tab[k]);
        end
        cycles += 1;
        avg = sum / N;
    endtask

    task automatic run_seq(input int ready_delay);
        int exp_cyc, exp_avg, exp_win, cyc, low_cnt;
        bit exp_to;
        model_seq(exp_cyc, exp_to, exp_avg, exp_win);
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        cyc = 1;
        check_val("seq_busy", bus.busy, 1);
        check_val("seq_err_clr", bus.timeout_err, 0);
        low_cnt = bus.est_stop ? 0 : 1;
        while (cyc < 3000) begin
            if (bus.avg_valid || bus.timeout_err) break;
            bus.start = (start_noise && $urandom_range(0, 15) == 0);
            @(negedge clk);
            cyc++;
            if (!bus.est_stop) low_cnt++;
        end
        bus.start = 1'b0;
        check_val("latency", cyc, exp_cyc);
        check_val("timeout_err", bus.timeout_err, exp_to);
        check_val("avg_valid", bus.avg_valid, !exp_to);
        check_val("stop_low_clks", low_cnt, exp_win * R);
        if (!exp_to) begin
            check_val("avg_result", bus.avg_result, exp_avg);
            for (int i = 0; i < ready_delay; i++) begin
                @(negedge clk);
                check_val("hold_valid", bus.avg_valid, 1);
                check_val("hold_result", bus.avg_result, exp_avg);
            end
            bus.avg_ready = 1'b1;
            @(negedge clk);
            bus.avg_ready = 1'b0;
            check_val("release_valid", bus.avg_valid, 0);
            check_val("release_idle", bus.busy, 0);
        end else begin
            check_val("timeout_idle", bus.busy, 0);
        end
    endtask

    initial begin
        bus.start     = 1'b0;
        bus.abort     = 1'b0;
        bus.avg_ready = 1'b0;
        for (int k = 0; k < N; k++) begin
            d_tab[k] = 2;
            v_tab[k] = '0;
        end

        // Reset state
        repeat (8) @(posedge clk);
        @(negedge clk);
        check_val("rst_est_stop", bus.est_stop, 1);
        check_val("rst_busy", bus.busy, 0);
        check_val("rst_avg_valid", bus.avg_valid, 0);
        check_val("rst_avg_result", bus.avg_result, 0);
        check_val("rst_timeout_err", bus.timeout_err, 0);
        RESETn = 1'b1;

        // Nominal average with a held-off consumer
        for (int k = 0; k < N; k++) begin
            d_tab[k] = 2;
            v_tab[k] = CNT_W'(100 + k);
        end
        run_seq(10);

        // Second measurement never answers
        d_tab[1] = 0;
        run_seq(0);
        d_tab[1] = 2;
        run_seq(0);

        // Abort during the third RUN window
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (54) @(negedge clk);
        check_val("abort_in_run", bus.est_stop, 0);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        check_val("abort_idle", bus.busy, 0);
        check_val("abort_est_stop", bus.est_stop, 1);
        check_val("abort_avg_valid", bus.avg_valid, 0);
        check_val("abort_err_kept", bus.timeout_err, 0);
        for (int k = 0; k < N; k++) v_tab[k] = '1;
        run_seq(1);

        // start and abort together in IDLE
        @(negedge clk);
        bus.start = 1'b1;
        bus.abort = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        bus.abort = 1'b0;
        check_val("start_abort_idle", bus.busy, 0);

        // Randomized sequences with noise on start and on est_valid during RUN
        run_noise   = 1'b1;
        start_noise = 1'b1;
        for (int s = 0; s < 8; s++) begin
            for (int k = 0; k < N; k++) begin
                d_tab[k] = ($urandom_range(0, 9) == 0) ? 0 : int'($urandom_range(1, S + T));
                v_tab[k] = CNT_W'($urandom_range(0, (1 << CNT_W) - 1));
            end
            run_seq(int'($urandom_range(0, 4)));
        end
        run_noise   = 1'b0;
        start_noise = 1'b0;

        // Asynchronous reset mid-sequence, observed before any clock edge
        for (int k = 0; k < N; k++) d_tab[k] = 2;
        @(negedge clk);
        bus.start = 1'b1;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (40) @(negedge clk);
        #2 RESETn = 1'b0;
        #1;
        check_val("arst_busy", bus.busy, 0);
        check_val("arst_est_stop", bus.est_stop, 1);
        check_val("arst_avg_valid", bus.avg_valid, 0);
        check_val("arst_avg_result", bus.avg_result, 0);
        repeat (2) @(negedge clk);
        RESETn = 1'b1;
        for (int k = 0; k < N; k++) v_tab[k] = CNT_W'(4 * k + 7);
        run_seq(0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
